// File: rtl/mmcm0_rst_seq.sv
// mmcm0_rst_seq: MMCM reset pulse, lock supervision with retry, and downstream reset release
module mmcm0_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       CLK_100,
    input  logic       RST,
    input  logic       LOCKED_ASYNC,
    output logic       MMCM_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       LOCK_FAIL,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);
    typedef enum logic [2:0] {
        S_RST_MMCM  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       retry_n;
    logic [7:0]       loss_n;
    logic             mmcm_rst_n, ready_n, lock_fail_n;
    (* ASYNC_REG = "TRUE" *) logic [1:0] sync;
    logic             lock_s;

    assign lock_s = sync[1];

    // two-flop synchroniser for the asynchronous MMCM lock indication
    always_ff @(posedge CLK_100) begin
        if (RST) sync <= 2'b00;
        else     sync <= {sync[0], LOCKED_ASYNC};
    end

    // next-state, cycle counter, retry and loss bookkeeping
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        retry_n = RETRY_CNT;
        loss_n  = LOSS_CNT;
        case (state)
            S_RST_MMCM: begin
                if (cnt == RST_LAST) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = S_STABLE;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_n   = '0;
                    state_n = (RETRY_CNT == RETRY_MAX) ? S_FAIL : S_RST_MMCM;
                    retry_n = (RETRY_CNT == RETRY_MAX) ? RETRY_CNT : RETRY_CNT + 4'd1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                    retry_n = 4'd0;
                end
            end
            S_RUN: begin
                cnt_n   = '0;
                retry_n = 4'd0;
                if (!lock_s) begin
                    state_n = S_RST_MMCM;
                    loss_n  = (LOSS_CNT == 8'hFF) ? LOSS_CNT : LOSS_CNT + 8'd1;
                end
            end
            S_FAIL: cnt_n = '0;
            default: begin
                state_n = S_RST_MMCM;
                cnt_n   = '0;
            end
        endcase
    end

    // output levels follow the state being entered so that they register alongside it
    always_comb begin
        mmcm_rst_n  = (state_n == S_RST_MMCM) || (state_n == S_FAIL);
        ready_n     = (state_n == S_RUN);
        lock_fail_n = (state_n == S_FAIL);
    end

    // state and registered outputs
    always_ff @(posedge CLK_100) begin
        if (RST) begin
            state     <= S_RST_MMCM;
            cnt       <= '0;
            RETRY_CNT <= 4'd0;
            LOSS_CNT  <= 8'd0;
            MMCM_RST  <= 1'b1;
            SYS_RST   <= 1'b1;
            READY     <= 1'b0;
            LOCK_FAIL <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            RETRY_CNT <= retry_n;
            LOSS_CNT  <= loss_n;
            MMCM_RST  <= mmcm_rst_n;
            SYS_RST   <= ~ready_n;
            READY     <= ready_n;
            LOCK_FAIL <= lock_fail_n;
        end
    end
endmodule

// File: tb/tb_mmcm0_rst_seq.sv
// tb_mmcm0_rst_seq: directed bring-up, glitch, retry, failure, loss and reset scenarios
module tb_mmcm0_rst_seq;
    logic       CLK_100, RST, LOCKED_ASYNC;
    logic       MMCM_RST, SYS_RST, READY, LOCK_FAIL;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n;
    int         loss_exp;

    mmcm0_rst_seq #(
        .RST_CYCLES(16), .LOCK_TIMEOUT(100), .STABLE_CYCLES(32), .MAX_RETRY(2), .CNT_W(16)
    ) dut (
        .CLK_100(CLK_100), .RST(RST), .LOCKED_ASYNC(LOCKED_ASYNC),
        .MMCM_RST(MMCM_RST), .SYS_RST(SYS_RST), .READY(READY), .LOCK_FAIL(LOCK_FAIL),
        .RETRY_CNT(RETRY_CNT), .LOSS_CNT(LOSS_CNT)
    );

    initial CLK_100 = 1'b0;
    always #5 CLK_100 = ~CLK_100;

    task automatic tick();
        @(posedge CLK_100);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return MMCM_RST;
            1:       return READY;
            2:       return SYS_RST;
            default: return LOCK_FAIL;
        endcase
    endfunction

    task automatic wait_for(input int w, input logic v, input int budget, output int cycles);
        cycles = 0;
        while (sig(w) !== v && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mmcm_rst"}, 32'(MMCM_RST), 1);
        chk({tag, "_sys_rst"}, 32'(SYS_RST), 1);
        chk({tag, "_ready"}, 32'(READY), 0);
        chk({tag, "_lock_fail"}, 32'(LOCK_FAIL), 0);
        chk({tag, "_retry"}, 32'(RETRY_CNT), 0);
        chk({tag, "_loss"}, 32'(LOSS_CNT), 0);
    endtask

    initial begin
        RST = 1'b1;
        LOCKED_ASYNC = 1'b0;
        repeat (5) tick();
        chk_reset_vals("por");
        RST = 1'b0;
        wait_for(0, 1'b0, 50, n);
        chk("t1_mmcm_width", n, 16);
        repeat (40) tick();
        chk("t1_no_timeout", 32'(MMCM_RST), 0);
        LOCKED_ASYNC = 1'b1;
        wait_for(1, 1'b1, 100, n);
        chk("t1_release_lat", n, 35);
        chk("t1_sys_rst", 32'(SYS_RST), 0);
        chk("t1_retry", 32'(RETRY_CNT), 0);
        chk("t1_mmcm_low", 32'(MMCM_RST), 0);

        loss_exp = 0;
        for (int i = 0; i < 300; i++) begin
            LOCKED_ASYNC = 1'b0;
            tick();
            LOCKED_ASYNC = 1'b1;
            wait_for(2, 1'b1, 10, n);
            chk("t5_loss_lat", n + 1, 3);
            chk("t5_mmcm_reissue", 32'(MMCM_RST), 1);
            loss_exp = (loss_exp < 255) ? loss_exp + 1 : 255;
            chk("t5_loss_cnt", 32'(LOSS_CNT), loss_exp);
            wait_for(1, 1'b1, 200, n);
            chk("t5_relock", 32'(READY), 1);
        end
        chk("t5_loss_sat", 32'(LOSS_CNT), 255);

        LOCKED_ASYNC = 1'b0;
        wait_for(0, 1'b1, 10, n);
        chk("t2_loss_lat", n, 3);
        wait_for(0, 1'b0, 50, n);
        chk("t2_mmcm_width", n, 16);
        repeat (10) tick();
        LOCKED_ASYNC = 1'b1;
        repeat (20) tick();
        chk("t2_stable_hold", 32'(SYS_RST), 1);
        LOCKED_ASYNC = 1'b0;
        repeat (3) tick();
        chk("t2_glitch_mmcm", 32'(MMCM_RST), 0);
        chk("t2_glitch_ready", 32'(READY), 0);
        chk("t2_glitch_retry", 32'(RETRY_CNT), 0);
        LOCKED_ASYNC = 1'b1;
        wait_for(1, 1'b1, 100, n);
        chk("t2_release_lat", n, 35);
        chk("t2_retry", 32'(RETRY_CNT), 0);
        chk("t2_loss", 32'(LOSS_CNT), 255);

        LOCKED_ASYNC = 1'b0;
        wait_for(0, 1'b1, 10, n);
        wait_for(0, 1'b0, 50, n);
        repeat (5) tick();
        LOCKED_ASYNC = 1'b1;
        repeat (10) tick();
        chk("t6a_in_stable", 32'(SYS_RST), 1);
        RST = 1'b1;
        LOCKED_ASYNC = 1'b0;
        tick();
        chk_reset_vals("t6a");
        RST = 1'b0;
        wait_for(0, 1'b0, 50, n);
        chk("t6a_mmcm_width", n, 16);

        wait_for(0, 1'b1, 200, n);
        chk("t3_timeout", n, 100);
        chk("t3_retry1", 32'(RETRY_CNT), 1);
        chk("t3_no_fail", 32'(LOCK_FAIL), 0);
        wait_for(0, 1'b0, 50, n);
        chk("t3_mmcm_width", n, 16);
        repeat (34) tick();
        LOCKED_ASYNC = 1'b1;
        repeat (10) tick();
        chk("t3_retry_hold", 32'(RETRY_CNT), 1);
        wait_for(1, 1'b1, 100, n);
        chk("t3_release_lat", n, 25);
        chk("t3_retry_clr", 32'(RETRY_CNT), 0);

        RST = 1'b1;
        LOCKED_ASYNC = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        wait_for(0, 1'b0, 50, n);
        chk("t4_mmcm_width0", n, 16);
        for (int p = 0; p < 3; p++) begin
            wait_for(0, 1'b1, 200, n);
            chk("t4_gap", n, 100);
            chk("t4_lock_fail", 32'(LOCK_FAIL), 32'(p == 2));
            if (p < 2) begin
                chk("t4_retry", 32'(RETRY_CNT), p + 1);
                wait_for(0, 1'b0, 50, n);
                chk("t4_mmcm_width", n, 16);
            end
        end
        chk("t4_retry_final", 32'(RETRY_CNT), 2);
        chk("t4_sys_rst", 32'(SYS_RST), 1);
        chk("t4_ready", 32'(READY), 0);
        LOCKED_ASYNC = 1'b1;
        repeat (50) tick();
        chk("t4_sticky_fail", 32'(LOCK_FAIL), 1);
        chk("t4_sticky_mmcm", 32'(MMCM_RST), 1);
        chk("t4_sticky_ready", 32'(READY), 0);

        RST = 1'b1;
        tick();
        chk_reset_vals("t6b");
        RST = 1'b0;
        wait_for(0, 1'b0, 50, n);
        chk("t6b_mmcm_width", n, 16);
        wait_for(1, 1'b1, 100, n);
        chk("t6b_release_lat", n, 33);
        chk("t6b_lock_fail", 32'(LOCK_FAIL), 0);
        chk("t6b_loss", 32'(LOSS_CNT), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
